// File: rtl/puf_response_packer.sv
// Packs one PUF response bit per counter-done rising edge into a RESP_BITS word, first bit in the MSB.
// Optional: define PACKER_MARGIN_EN to add the per-bit `unstable` flag output.
module puf_response_packer #(
  parameter int         RESP_BITS = 16,
  parameter logic [6:0] THRESHOLD = 7'd64,
  parameter logic [6:0] MARGIN    = 7'd4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [6:0]           count_in,
  input  logic                 count_done,
  output logic                 cnt_en,
  output logic                 cnt_clr,
  output logic [RESP_BITS-1:0] resp_data,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic                 busy
`ifdef PACKER_MARGIN_EN
  ,
  output logic [RESP_BITS-1:0] unstable
`endif
);

  localparam int               IDX_W    = $clog2(RESP_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RESP_BITS - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, COUNT, HOLD} state_t;

  state_t               state_q;
  logic [IDX_W-1:0]     idx_q;
  logic                 done_q;
  logic                 cnt_en_q;
  logic                 cnt_clr_q;
  logic                 resp_valid_q;
  logic                 busy_q;
  logic [RESP_BITS-1:0] shift_q;

  logic capture_d;
  logic resp_bit_d;

  // Only a fresh low-to-high transition of count_done inside COUNT captures a bit.
  assign capture_d  = (state_q == COUNT) && count_done && !done_q;
  assign resp_bit_d = (count_in >= THRESHOLD);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      done_q       <= 1'b0;
      cnt_en_q     <= 1'b0;
      cnt_clr_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      shift_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_en_q  <= 1'b0;
          cnt_clr_q <= 1'b0;
          if (start) begin
            state_q   <= CLEAR;
            idx_q     <= '0;
            shift_q   <= '0;
            cnt_clr_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        CLEAR: begin
          // Force done_q high so a done level left over from the last bit is not taken as an edge.
          done_q    <= 1'b1;
          cnt_clr_q <= 1'b0;
          cnt_en_q  <= 1'b1;
          state_q   <= COUNT;
        end
        COUNT: begin
          done_q <= count_done;
          if (capture_d) begin
            shift_q  <= {shift_q[RESP_BITS-2:0], resp_bit_d};
            cnt_en_q <= 1'b0;
            if (idx_q == LAST_IDX) begin
              state_q      <= HOLD;
              resp_valid_q <= 1'b1;
            end else begin
              idx_q     <= idx_q + 1'b1;
              state_q   <= CLEAR;
              cnt_clr_q <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (resp_ready) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cnt_en     = cnt_en_q;
  assign cnt_clr    = cnt_clr_q;
  assign resp_valid = resp_valid_q;
  assign busy       = busy_q;
  assign resp_data  = shift_q;

`ifdef PACKER_MARGIN_EN
  logic [RESP_BITS-1:0] unstable_q;
  logic [7:0]           diff_d;
  logic [7:0]           mag_d;
  logic                 unstable_bit_d;

  // Signed 8-bit distance from threshold; a bit this close may flip between acquisitions.
  assign diff_d         = {1'b0, count_in} - {1'b0, THRESHOLD};
  assign mag_d          = diff_d[7] ? (8'd0 - diff_d) : diff_d;
  assign unstable_bit_d = (mag_d < {1'b0, MARGIN});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      unstable_q <= '0;
    end else if (state_q == IDLE && start) begin
      unstable_q <= '0;
    end else if (capture_d) begin
      unstable_q <= {unstable_q[RESP_BITS-2:0], unstable_bit_d};
    end
  end

  assign unstable = unstable_q;
`endif

endmodule

// File: tb/tb_puf_response_packer.sv
// Self-checking bench for puf_response_packer: directed words, a queue model of captured bits,
// and a per-cycle compare process on the falling edge.
module tb_puf_response_packer;
  localparam int         RB = 16;
  localparam logic [6:0] TH = 7'd64;
  localparam logic [6:0] MG = 7'd4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [6:0]    count_in = '0;
  logic          count_done = 1'b0;
  logic          resp_ready = 1'b0;
  logic          cnt_en, cnt_clr, resp_valid, busy;
  logic [RB-1:0] resp_data;
`ifdef PACKER_MARGIN_EN
  logic [RB-1:0] unstable;
`endif

  int checks = 0;
  int failures = 0;
  bit exp_busy = 1'b0;
  bit exp_valid = 1'b0;
  bit exp_bits[$];
  bit exp_unst[$];
  int clr_pulses = 0;
  bit prev_clr = 1'b0;
  bit held = 1'b0;
  logic [RB-1:0] held_data = '0;

  always #5 clk = ~clk;

  puf_response_packer #(.RESP_BITS(RB), .THRESHOLD(TH), .MARGIN(MG)) dut (
    .clk(clk), .reset(reset), .start(start), .count_in(count_in), .count_done(count_done),
    .cnt_en(cnt_en), .cnt_clr(cnt_clr), .resp_data(resp_data), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .busy(busy)
`ifdef PACKER_MARGIN_EN
    , .unstable(unstable)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Word the captured bits must form: bit i of the capture order lands at position RB-1-i.
  function automatic logic [RB-1:0] pack(input bit q[$]);
    logic [RB-1:0] w = '0;
    for (int i = 0; i < q.size() && i < RB; i++)
      if (q[i]) w = w | (RB'(1) << (RB - 1 - i));
    return w;
  endfunction

  function automatic bit near_threshold(input logic [6:0] v);
    int d = int'(v) - int'(TH);
    if (d < 0) d = -d;
    return d < int'(MG);
  endfunction

  // Compare process: runs every falling edge.
  always @(negedge clk) begin
    if (!reset)
      check("reset_outputs", {12'd0, cnt_en, cnt_clr, resp_valid, busy, resp_data}, 32'd0);
    check("busy", busy, exp_busy);
    check("resp_valid", resp_valid, exp_valid);
    if (!exp_busy || exp_valid) check("cnt_en_inactive", cnt_en, 1'b0);
    check("clr_en_exclusive", cnt_en & cnt_clr, 1'b0);
    if (prev_clr) check("clr_single_cycle", cnt_clr, 1'b0);
    if (exp_valid) check("resp_data_model", resp_data, pack(exp_bits));
    if (resp_valid && held) check("resp_data_stable", resp_data, held_data);
`ifdef PACKER_MARGIN_EN
    if (exp_valid) check("unstable_model", unstable, pack(exp_unst));
    if (!reset) check("unstable_reset", unstable, '0);
`endif
    if (cnt_clr) clr_pulses++;
    prev_clr = cnt_clr;
    held = resp_valid;
    held_data = resp_data;
  end

  // All stimulus tasks begin and end 1 time unit after a rising edge.
  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    exp_busy = 1'b1;
    exp_bits.delete();
    exp_unst.delete();
    clr_pulses = 0;
  endtask

  // Entered with the DUT in CLEAR; stale=1 keeps count_done high into COUNT before the real edge.
  task automatic acquire_bit(input logic [6:0] val, input bit stale);
    count_in = val;
    count_done = stale;
    @(posedge clk); #1;
    if (stale) begin
      repeat (3) begin @(posedge clk); #1; end
      count_done = 1'b0;
    end
    @(posedge clk); #1;
    count_done = 1'b1;
    @(posedge clk); #1;
    exp_bits.push_back(val >= TH);
    exp_unst.push_back(near_threshold(val));
    if (exp_bits.size() == RB) exp_valid = 1'b1;
  endtask

  task automatic run_word(input logic [6:0] vals[RB], input logic [RB-1:0] stale_mask);
    do_start();
    for (int i = 0; i < RB; i++) acquire_bit(vals[i], stale_mask[i]);
    count_done = 1'b0;
  endtask

  task automatic accept();
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    exp_valid = 1'b0;
    exp_busy = 1'b0;
    check("idle_after_accept", {resp_valid, busy}, 2'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0]    vals[RB];
    logic [RB-1:0] w;

    // Reset with random inputs, then release with start low.
    #2 reset = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      start = 1'($urandom); count_done = 1'($urandom);
      resp_ready = 1'($urandom); count_in = 7'($urandom);
    end
    start = 1'b0; count_done = 1'b0; resp_ready = 1'b0; count_in = '0;
    reset = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    check("post_reset_idle", {12'd0, cnt_en, cnt_clr, resp_valid, busy, resp_data}, 32'd0);

    // Alternating 100/10 -> 0xAAAA.
    for (int i = 0; i < RB; i++) vals[i] = (i % 2 == 0) ? 7'd100 : 7'd10;
    run_word(vals, '0);
    check("pack_valid_after_last_edge", resp_valid, 1'b1);
    check("pack_data_literal", resp_data, 16'hAAAA);
    check("pack_model_literal", pack(exp_bits), 16'hAAAA);
    check("pack_clr_pulses", clr_pulses, 16);
    accept();

    // Threshold boundaries -> 0xA5C3, then held under backpressure with start pulses.
    vals = '{7'd64, 7'd63, 7'd127, 7'd0, 7'd0, 7'd127, 7'd63, 7'd64,
             7'd64, 7'd64, 7'd63, 7'd63, 7'd0, 7'd0, 7'd127, 7'd127};
    run_word(vals, '0);
    check("boundary_data_literal", resp_data, 16'hA5C3);
    w = resp_data;
    for (int c = 0; c < 20; c++) begin
      start = (c % 3 == 0);
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("backpressure_valid", resp_valid, 1'b1);
    check("backpressure_data", resp_data, w);
    accept();

    // Stale done levels on alternate bits, resp_ready held high throughout -> 0x00FF.
    for (int i = 0; i < RB; i++) vals[i] = 7'(i * 8);
    resp_ready = 1'b1;
    run_word(vals, 16'hAAAA);
    check("stale_data_literal", resp_data, 16'h00FF);
    check("stale_clr_pulses", clr_pulses, 16);
    accept();

    // Reset after the eighth capture: outputs drop without a clock edge.
    for (int i = 0; i < RB; i++) vals[i] = 7'd100;
    do_start();
    for (int i = 0; i < 8; i++) acquire_bit(vals[i], 1'b0);
    count_done = 1'b0;
    #2 reset = 1'b0;
    exp_busy = 1'b0; exp_valid = 1'b0;
    exp_bits.delete(); exp_unst.delete();
    #1 check("async_reset_outputs", {12'd0, cnt_en, cnt_clr, resp_valid, busy, resp_data}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    for (int c = 0; c < 10; c++) begin
      count_done = c[0];
      @(posedge clk); #1;
    end
    count_done = 1'b0;
    check("no_valid_without_start", {resp_valid, busy}, 2'b00);

    // Recovery after reset -> 0x5555.
    for (int i = 0; i < RB; i++) vals[i] = (i % 2 == 0) ? 7'd10 : 7'd100;
    run_word(vals, '0);
    check("recover_data_literal", resp_data, 16'h5555);
    accept();

`ifdef PACKER_MARGIN_EN
    // 62: stable-0 band edge flagged; 58: outside; 67: flagged and 1.
    vals = '{default: 7'd0};
    vals[0] = 7'd62; vals[1] = 7'd58; vals[2] = 7'd67;
    run_word(vals, '0);
    check("margin_resp_literal", resp_data, 16'h2000);
    check("margin_unstable_literal", unstable, 16'hA000);
    accept();
`endif

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
